// File: rtl/jesd204b_rx_link_ctrl_if.sv
// Link-control signal bundle between the JESD204B lane decoders / link driver and the
// receiver link controller. master = stimulus/driver side, slave = the controller.
interface jesd204b_rx_link_ctrl_if #(
    parameter int LANES = 4
);
    logic             link_en;
    logic [LANES-1:0] lane_mask;
    logic             sysref_i;
    logic             sysref_oneshot;
    logic [LANES-1:0] k_lock_i;
    logic [LANES-1:0] lane_err_i;
    logic [LANES-1:0] sync_b_o;
    logic             lmfc_o;
    logic             sysref_cap_o;
    logic             data_valid_o;
    logic [2:0]       state_o;
    logic [7:0]       resync_cnt_o;

    modport master (
        output link_en, lane_mask, sysref_i, sysref_oneshot, k_lock_i, lane_err_i,
        input  sync_b_o, lmfc_o, sysref_cap_o, data_valid_o, state_o, resync_cnt_o
    );

    modport slave (
        input  link_en, lane_mask, sysref_i, sysref_oneshot, k_lock_i, lane_err_i,
        output sync_b_o, lmfc_o, sysref_cap_o, data_valid_o, state_o, resync_cnt_o
    );
endinterface

// File: rtl/jesd204b_rx_link_ctrl.sv
// JESD204B receiver link-layer controller: LMFC generation with SYSREF alignment and the
// CGS -> WAIT_LMFC -> ILAS -> DATA sequence driving SYNC~ back to the transmitter.
module jesd204b_rx_link_ctrl #(
    parameter int LANES       = 4,
    parameter int LMFC_PERIOD = 32,
    parameter int CGS_HOLD    = 4,
    parameter int ILAS_MF     = 4,
    parameter int ERR_THRESH  = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    jesd204b_rx_link_ctrl_if.slave  lnk
);
    localparam int CW = $clog2(LMFC_PERIOD);
    localparam int GW = $clog2(CGS_HOLD + 1);
    localparam int IW = $clog2(ILAS_MF + 1);
    localparam int EW = $clog2(ERR_THRESH + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CGS       = 3'd1,
        WAIT_LMFC = 3'd2,
        ILAS      = 3'd3,
        DATA      = 3'd4
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    lmfc_cnt_q, lmfc_cnt_d;
    logic             lmfc_q, lmfc_d;
    logic             sysref_prev_q;
    logic             cap_q, cap_d;
    logic [GW-1:0]    cgs_cnt_q, cgs_cnt_d;
    logic [IW-1:0]    ilas_cnt_q, ilas_cnt_d;
    logic [EW-1:0]    err_cnt_q, err_cnt_d;
    logic [7:0]       resync_q, resync_d;
    logic [LANES-1:0] sync_b_q, sync_b_d;
    logic             dv_q, dv_d;

    logic             sysref_edge;
    logic             realign;
    logic             all_lock;
    logic             any_err;
    logic [EW-1:0]    err_base;
    logic [EW-1:0]    err_next;
    logic             err_hit;
    logic             resync_bump;

    // LMFC counter; a qualifying SYSREF edge forces count 0 on the following cycle.
    always_comb begin
        sysref_edge = lnk.sysref_i & ~sysref_prev_q;
        realign     = sysref_edge & (~cap_q | ~lnk.sysref_oneshot);
        if (realign || (lmfc_cnt_q == CW'(LMFC_PERIOD - 1))) begin
            lmfc_cnt_d = '0;
        end else begin
            lmfc_cnt_d = lmfc_cnt_q + 1'b1;
        end
        lmfc_d = (lmfc_cnt_d == '0);
    end

    // An empty mask never counts as locked so the link cannot come up with no lanes.
    always_comb begin
        all_lock = (|lnk.lane_mask) & (&(lnk.k_lock_i | ~lnk.lane_mask));
        any_err  = |(lnk.lane_err_i & lnk.lane_mask);
        err_base = lmfc_q ? '0 : err_cnt_q;
        err_next = err_base + EW'(any_err);
        err_hit  = (err_next >= EW'(ERR_THRESH));
    end

    always_comb begin
        state_d     = state_q;
        cgs_cnt_d   = '0;
        ilas_cnt_d  = ilas_cnt_q;
        resync_bump = 1'b0;

        if (!lnk.link_en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cap_q) state_d = CGS;
                end
                CGS: begin
                    if (all_lock) begin
                        if (cgs_cnt_q == GW'(CGS_HOLD - 1)) state_d = WAIT_LMFC;
                        else cgs_cnt_d = cgs_cnt_q + 1'b1;
                    end
                end
                WAIT_LMFC: begin
                    if (!all_lock) state_d = CGS;
                    else if (lmfc_q) state_d = ILAS;
                end
                ILAS, DATA: begin
                    if (!all_lock || err_hit) begin
                        state_d     = CGS;
                        resync_bump = 1'b1;
                    end else if ((state_q == ILAS) && lmfc_q) begin
                        if (ilas_cnt_q == IW'(ILAS_MF - 1)) state_d = DATA;
                        else ilas_cnt_d = ilas_cnt_q + 1'b1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        if (state_d != state_q) begin
            cgs_cnt_d  = '0;
            ilas_cnt_d = '0;
        end

        if ((state_d != state_q) || !((state_q == ILAS) || (state_q == DATA))) begin
            err_cnt_d = '0;
        end else begin
            err_cnt_d = err_next;
        end

        if (resync_bump && (resync_q != 8'hFF)) resync_d = resync_q + 8'd1;
        else resync_d = resync_q;

        // Entering IDLE re-arms SYSREF capture.
        if ((state_d == IDLE) && (state_q != IDLE)) cap_d = 1'b0;
        else cap_d = cap_q | sysref_edge;

        sync_b_d = ((state_d == ILAS) || (state_d == DATA)) ? '1 : '0;
        dv_d     = (state_d == DATA);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            lmfc_cnt_q    <= '0;
            lmfc_q        <= 1'b0;
            sysref_prev_q <= 1'b0;
            cap_q         <= 1'b0;
            cgs_cnt_q     <= '0;
            ilas_cnt_q    <= '0;
            err_cnt_q     <= '0;
            resync_q      <= '0;
            sync_b_q      <= '0;
            dv_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            lmfc_cnt_q    <= lmfc_cnt_d;
            lmfc_q        <= lmfc_d;
            sysref_prev_q <= lnk.sysref_i;
            cap_q         <= cap_d;
            cgs_cnt_q     <= cgs_cnt_d;
            ilas_cnt_q    <= ilas_cnt_d;
            err_cnt_q     <= err_cnt_d;
            resync_q      <= resync_d;
            sync_b_q      <= sync_b_d;
            dv_q          <= dv_d;
        end
    end

    assign lnk.sync_b_o     = sync_b_q;
    assign lnk.lmfc_o       = lmfc_q;
    assign lnk.sysref_cap_o = cap_q;
    assign lnk.data_valid_o = dv_q;
    assign lnk.state_o      = state_q;
    assign lnk.resync_cnt_o = resync_q;
endmodule

// File: tb/tb_jesd204b_rx_link_ctrl.sv
// Bench for jesd204b_rx_link_ctrl: directed link scenarios plus a random soak, every cycle
// compared against a cycle-level behavioural model of the link rules.
module tb_jesd204b_rx_link_ctrl;
    localparam int LANES = 4;
    localparam int LMFC_PERIOD = 32;
    localparam int CGS_HOLD = 4;
    localparam int ILAS_MF = 4;
    localparam int ERR_THRESH = 8;
    localparam int S_IDLE = 0, S_CGS = 1, S_WAIT = 2, S_ILAS = 3, S_DATA = 4;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    jesd204b_rx_link_ctrl_if #(.LANES(LANES)) lnk ();

    jesd204b_rx_link_ctrl #(
        .LANES(LANES), .LMFC_PERIOD(LMFC_PERIOD), .CGS_HOLD(CGS_HOLD),
        .ILAS_MF(ILAS_MF), .ERR_THRESH(ERR_THRESH)
    ) dut (
        .clk(clk),
        .reset(reset),
        .lnk(lnk)
    );

    // Reference model state: values the DUT outputs should show after the current edge.
    int m_state, m_phase, m_lockrun, m_mf, m_errs, m_resync;
    bit m_prev, m_cap, m_lmfc;

    task automatic model_step();
        bit edge_s, realign, lock, err, bump;
        int nstate, nphase, errs_now;
        if (reset) begin
            m_state = S_IDLE; m_phase = 0; m_lockrun = 0; m_mf = 0; m_errs = 0;
            m_resync = 0; m_prev = 0; m_cap = 0; m_lmfc = 0;
            return;
        end
        edge_s   = lnk.sysref_i && !m_prev;
        realign  = edge_s && (!m_cap || !lnk.sysref_oneshot);
        nphase   = realign ? 0 : (m_phase + 1) % LMFC_PERIOD;
        lock     = (lnk.lane_mask != 0) && ((lnk.k_lock_i & lnk.lane_mask) == lnk.lane_mask);
        err      = (lnk.lane_err_i & lnk.lane_mask) != 0;
        errs_now = (m_lmfc ? 0 : m_errs) + int'(err);
        nstate   = m_state;
        bump     = 0;
        if (!lnk.link_en) nstate = S_IDLE;
        else if (m_state == S_IDLE) begin
            if (m_cap) nstate = S_CGS;
        end else if (m_state == S_CGS) begin
            m_lockrun = lock ? m_lockrun + 1 : 0;
            if (m_lockrun >= CGS_HOLD) nstate = S_WAIT;
        end else if (m_state == S_WAIT) begin
            if (!lock) nstate = S_CGS;
            else if (m_lmfc) nstate = S_ILAS;
        end else begin
            if (!lock || errs_now >= ERR_THRESH) begin
                nstate = S_CGS;
                bump = 1;
            end else if (m_state == S_ILAS && m_lmfc) begin
                m_mf++;
                if (m_mf == ILAS_MF) nstate = S_DATA;
            end
        end
        if (nstate != m_state) begin
            m_lockrun = 0;
            m_mf = 0;
        end
        m_errs = (nstate == m_state && (m_state == S_ILAS || m_state == S_DATA)) ? errs_now : 0;
        if (bump && m_resync < 255) m_resync++;
        if (nstate == S_IDLE && m_state != S_IDLE) m_cap = 0;
        else m_cap = m_cap || edge_s;
        m_prev  = lnk.sysref_i;
        m_phase = nphase;
        m_lmfc  = (nphase == 0);
        m_state = nstate;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [3:0] exp_sync;
        model_step();
        @(posedge clk);
        #1;
        exp_sync = (m_state == S_ILAS || m_state == S_DATA) ? 4'hF : 4'h0;
        chk("state", 32'(lnk.state_o), 32'(m_state));
        chk("sync_b", 32'(lnk.sync_b_o), 32'(exp_sync));
        chk("lmfc", 32'(lnk.lmfc_o), 32'(m_lmfc));
        chk("sysref_cap", 32'(lnk.sysref_cap_o), 32'(m_cap));
        chk("data_valid", 32'(lnk.data_valid_o), 32'(m_state == S_DATA));
        chk("resync_cnt", 32'(lnk.resync_cnt_o), 32'(m_resync));
    endtask

    task automatic wait_state(input int target, input int budget);
        int n = 0;
        while (lnk.state_o !== 3'(target) && n < budget) begin
            tick();
            n++;
        end
        chk("wait_state", 32'(lnk.state_o), 32'(target));
    endtask

    task automatic wait_lmfc(input int budget);
        int n = 0;
        while (lnk.lmfc_o !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk("wait_lmfc", 32'(lnk.lmfc_o), 32'd1);
    endtask

    task automatic pulse_sysref();
        lnk.sysref_i = 1'b1;
        tick();
        lnk.sysref_i = 1'b0;
        tick();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        logic prev_lmfc;
        reset = 1'b1;
        lnk.link_en = 1'b0; lnk.lane_mask = '0; lnk.sysref_i = 1'b0;
        lnk.sysref_oneshot = 1'b0; lnk.k_lock_i = '0; lnk.lane_err_i = '0;
        tick();
        tick();
        chk("rst_state", 32'(lnk.state_o), 32'd0);
        chk("rst_sync_b", 32'(lnk.sync_b_o), 32'd0);
        chk("rst_cap", 32'(lnk.sysref_cap_o), 32'd0);
        reset = 1'b0;

        // Bring-up: CGS hold, SYNC~ release on an LMFC boundary, ILAS length.
        lnk.link_en = 1'b1; lnk.lane_mask = 4'hF; lnk.k_lock_i = 4'hF;
        repeat (3) tick();
        chk("idle_until_sysref", 32'(lnk.state_o), 32'd0);
        pulse_sysref();
        chk("enter_cgs", 32'(lnk.state_o), 32'd1);
        n = 0;
        while (lnk.state_o === 3'd1 && n < 20) begin tick(); n++; end
        chk("cgs_hold_cycles", 32'(n), 32'(CGS_HOLD));
        n = 0;
        prev_lmfc = 1'b0;
        while (lnk.sync_b_o !== 4'hF && n < 40) begin prev_lmfc = lnk.lmfc_o; tick(); n++; end
        chk("sync_rise_on_lmfc", 32'(prev_lmfc), 32'd1);
        n = 0;
        while (lnk.data_valid_o !== 1'b1 && n < 200) begin tick(); n++; end
        chk("ilas_length", 32'(n), 32'(ILAS_MF * LMFC_PERIOD));

        // SYSREF realign at count 17, then a one-shot edge that must not shift the LMFC.
        tick();
        wait_lmfc(40);
        repeat (17) tick();
        lnk.sysref_oneshot = 1'b0; lnk.sysref_i = 1'b1;
        tick();
        lnk.sysref_i = 1'b0;
        chk("realign_pulse", 32'(lnk.lmfc_o), 32'd1);
        n = 0;
        do begin tick(); n++; end while (lnk.lmfc_o !== 1'b1 && n < 40);
        chk("realign_period", 32'(n), 32'(LMFC_PERIOD));
        lnk.sysref_oneshot = 1'b1;
        repeat (10) tick();
        lnk.sysref_i = 1'b1;
        tick();
        lnk.sysref_i = 1'b0;
        n = 11;
        while (lnk.lmfc_o !== 1'b1 && n < 40) begin tick(); n++; end
        chk("oneshot_no_shift", 32'(n), 32'(LMFC_PERIOD));

        // Lock loss on lane 2, then the same drop with lane 2 masked out.
        lnk.k_lock_i = 4'hB;
        tick();
        lnk.k_lock_i = 4'hF;
        chk("lockloss_state", 32'(lnk.state_o), 32'd1);
        chk("lockloss_sync_b", 32'(lnk.sync_b_o), 32'd0);
        chk("lockloss_resync", 32'(lnk.resync_cnt_o), 32'd1);
        wait_state(S_DATA, 250);
        lnk.lane_mask = 4'hB;
        repeat (8) begin
            lnk.k_lock_i = {1'b1, 1'($urandom), 2'b11};
            lnk.lane_err_i = {1'b0, 1'($urandom), 2'b00};
            tick();
        end
        lnk.k_lock_i = 4'hF; lnk.lane_err_i = '0; lnk.lane_mask = 4'hF;
        chk("masked_drop_state", 32'(lnk.state_o), 32'd4);
        chk("masked_drop_resync", 32'(lnk.resync_cnt_o), 32'd1);

        // Error window: 7 strobes tolerated, 8 forces resync, 7 + boundary + 7 tolerated.
        tick();
        wait_lmfc(40);
        tick();
        repeat (ERR_THRESH - 1) begin lnk.lane_err_i = 4'($urandom_range(1, 15)); tick(); end
        lnk.lane_err_i = '0;
        wait_lmfc(40);
        chk("err7_state", 32'(lnk.state_o), 32'd4);
        tick();
        repeat (ERR_THRESH) begin lnk.lane_err_i = 4'($urandom_range(1, 15)); tick(); end
        lnk.lane_err_i = '0;
        chk("err8_state", 32'(lnk.state_o), 32'd1);
        chk("err8_resync", 32'(lnk.resync_cnt_o), 32'd2);
        wait_state(S_DATA, 250);
        tick();
        wait_lmfc(40);
        repeat (24) tick();
        repeat (ERR_THRESH - 1) begin lnk.lane_err_i = 4'($urandom_range(1, 15)); tick(); end
        lnk.lane_err_i = '0;
        tick();
        tick();
        repeat (ERR_THRESH - 1) begin lnk.lane_err_i = 4'($urandom_range(1, 15)); tick(); end
        lnk.lane_err_i = '0;
        chk("err_split_state", 32'(lnk.state_o), 32'd4);

        // Disable during ILAS, then re-enable requires a fresh SYSREF.
        lnk.k_lock_i = 4'h7;
        tick();
        lnk.k_lock_i = 4'hF;
        wait_state(S_ILAS, 60);
        tick();
        tick();
        lnk.link_en = 1'b0;
        tick();
        chk("disable_state", 32'(lnk.state_o), 32'd0);
        chk("disable_sync_b", 32'(lnk.sync_b_o), 32'd0);
        chk("disable_cap", 32'(lnk.sysref_cap_o), 32'd0);
        lnk.link_en = 1'b1;
        repeat (10) tick();
        chk("reenable_waits", 32'(lnk.state_o), 32'd0);
        pulse_sysref();
        chk("reenable_cgs", 32'(lnk.state_o), 32'd1);

        // Reset mid-DATA, then drive the resync counter into saturation.
        wait_state(S_DATA, 250);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("midrst_state", 32'(lnk.state_o), 32'd0);
        chk("midrst_resync", 32'(lnk.resync_cnt_o), 32'd0);
        chk("midrst_dv", 32'(lnk.data_valid_o), 32'd0);
        chk("midrst_lmfc", 32'(lnk.lmfc_o), 32'd0);
        pulse_sysref();
        for (int i = 0; i < 260; i++) begin
            wait_state(S_ILAS, 80);
            lnk.k_lock_i = 4'hF & ~(4'b1 << $urandom_range(0, LANES - 1));
            tick();
            lnk.k_lock_i = 4'hF;
        end
        chk("resync_saturate", 32'(lnk.resync_cnt_o), 32'd255);

        // Random soak against the model with varying error density.
        lnk.sysref_oneshot = 1'($urandom);
        for (int i = 0; i < 3000; i++) begin
            int err_div;
            err_div = ((i / 500) % 3 == 0) ? 0 : (((i / 500) % 3 == 1) ? 10 : 4);
            lnk.link_en = ($urandom_range(0, 199) != 0);
            lnk.sysref_i = ($urandom_range(0, 79) == 0);
            if ($urandom_range(0, 255) == 0) lnk.sysref_oneshot = 1'($urandom);
            if ($urandom_range(0, 299) == 0) lnk.lane_mask = 4'($urandom);
            lnk.k_lock_i = ($urandom_range(0, 399) == 0) ? 4'($urandom) : 4'hF;
            lnk.lane_err_i = (err_div != 0 && $urandom_range(0, err_div - 1) == 0) ? 4'($urandom) : 4'h0;
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
